// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
// Channel state encoding, button indices and the ms-tick divider.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'b00,
        PRESS_DB   = 2'b01,
        PRESSED    = 2'b10,
        RELEASE_DB = 2'b11
    } chState_e;

    localparam int BTN_FEED    = 0;
    localparam int BTN_LIGHT   = 1;
    localparam int BTN_ECHO    = 2;
    localparam int BTN_HEAL    = 3;
    localparam int BTN_CHSTATE = 4;
    localparam int BTN_TEST    = 5;

    // Clock cycles per 1 ms tick.
    function automatic int msTickDiv(input int clkFreq);
        return clkFreq / 1000;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board inputs and the pet-state FSM.
// master drives the raw buttons, slave is the conditioner.
interface button_conditioner_if #(
    parameter int NBTN = 6
);
    logic [NBTN-1:0] btn_n;
    logic [NBTN-1:0] press_pulse;
    logic [NBTN-1:0] release_pulse;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] long_pulse;
    logic            tick_ms;

    modport master (
        output btn_n,
        input  press_pulse,
        input  release_pulse,
        input  level,
        input  long_pulse,
        input  tick_ms
    );

    modport slave (
        input  btn_n,
        output press_pulse,
        output release_pulse,
        output level,
        output long_pulse,
        output tick_ms
    );
endinterface

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: synchronizer, debounce FSM, hold timer.
// Pulses are registered so they line up with the level change.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btnN,
    output logic pressPulse,
    output logic releasePulse,
    output logic level,
    output logic longPulse
);
    localparam int DBW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW  = $clog2(LONG_PRESS_MS + 1);

    logic           s1;
    logic           s2;
    logic           raw;
    chState_e       state;
    chState_e       stateN;
    logic [DBW-1:0] dbCnt;
    logic [DBW-1:0] dbN;
    logic [HW-1:0]  holdCnt;
    logic [HW-1:0]  holdN;
    logic           longDone;
    logic           ldN;
    logic           ppN;
    logic           rpN;
    logic           lpN;

    assign raw   = ~s2;
    assign level = (state == PRESSED) || (state == RELEASE_DB);

    // Two-flop synchronizer; idles high (button released).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btnN;
            s2 <= s1;
        end
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RELEASED;
            dbCnt        <= '0;
            holdCnt      <= '0;
            longDone     <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            longPulse    <= 1'b0;
        end else begin
            state        <= stateN;
            dbCnt        <= dbN;
            holdCnt      <= holdN;
            longDone     <= ldN;
            pressPulse   <= ppN;
            releasePulse <= rpN;
            longPulse    <= lpN;
        end
    end

    // Next-state, debounce counting and hold timing.
    always_comb begin
        stateN = state;
        dbN    = dbCnt;
        holdN  = holdCnt;
        ldN    = longDone;
        ppN    = 1'b0;
        rpN    = 1'b0;
        lpN    = 1'b0;
        unique case (state)
            RELEASED: begin
                if (raw) begin
                    stateN = PRESS_DB;
                    dbN    = '0;
                end
            end
            PRESS_DB: begin
                if (!raw) begin
                    stateN = RELEASED;
                    dbN    = '0;
                end else if (tick) begin
                    if (dbCnt == DBW'(DEBOUNCE_MS - 1)) begin
                        stateN = PRESSED;
                        dbN    = '0;
                        ppN    = 1'b1;
                        holdN  = '0;
                        ldN    = 1'b0;
                    end else begin
                        dbN = dbCnt + 1'b1;
                    end
                end
            end
            PRESSED, RELEASE_DB: begin
                if (tick && holdCnt != HW'(LONG_PRESS_MS)) begin
                    holdN = holdCnt + 1'b1;
                    if (holdCnt == HW'(LONG_PRESS_MS - 1)
                        && !longDone) begin
                        lpN = 1'b1;
                        ldN = 1'b1;
                    end
                end
                if (state == PRESSED) begin
                    if (!raw) begin
                        stateN = RELEASE_DB;
                        dbN    = '0;
                    end
                end else if (raw) begin
                    stateN = PRESSED;
                    dbN    = '0;
                end else if (tick) begin
                    if (dbCnt == DBW'(DEBOUNCE_MS - 1)) begin
                        stateN = RELEASED;
                        dbN    = '0;
                        rpN    = 1'b1;
                    end else begin
                        dbN = dbCnt + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner top: shared 1 kHz prescaler
// plus one debounce channel per button.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NBTN          = 6,
    parameter int CLK_FREQ      = 50000000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 5000
) (
    input  logic clk,
    input  logic rst,
    button_conditioner_if.slave bus
);
    localparam int TDIV = msTickDiv(CLK_FREQ);
    localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;

    logic [TW-1:0] preCnt;
    logic          tick;

    assign tick        = (preCnt == TW'(TDIV - 1));
    assign bus.tick_ms = tick;

    // Free-running ms prescaler, wraps at TDIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            preCnt <= '0;
        end else if (tick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_MS  (DEBOUNCE_MS),
            .LONG_PRESS_MS(LONG_PRESS_MS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .btnN        (bus.btn_n[i]),
            .pressPulse  (bus.press_pulse[i]),
            .releasePulse(bus.release_pulse[i]),
            .level       (bus.level[i]),
            .longPulse   (bus.long_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner.
// TDIV=10, DEBOUNCE_MS=3, LONG_PRESS_MS=20.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    button_conditioner_if #(.NBTN(6)) bus ();

    button_conditioner #(
        .NBTN         (6),
        .CLK_FREQ     (10000),
        .DEBOUNCE_MS  (3),
        .LONG_PRESS_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One clock, sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.btn_n = '1;
        repeat (3) cyc();
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        logic [24:0] outs;
        logic        exp;
        rst = 1'b1;
        bus.btn_n = '1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            outs = {bus.press_pulse, bus.release_pulse, bus.level,
                    bus.long_pulse, bus.tick_ms};
            checks++;
            if (outs !== 25'd0) begin
                errors++;
                $display("FAIL reset_outs: got %h expected 0", outs);
            end
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            exp = ((k % 10) == 9);
            checks++;
            if (bus.tick_ms !== exp) begin
                errors++;
                $display("FAIL tick_k%0d: got %b expected %b",
                         k, bus.tick_ms, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        int   pc = 0;
        int   pk = -1;
        int   lc = 0;
        logic lv29 = 1'bx;
        int   lvBad = 0;
        apply_reset();
        bus.btn_n[0] = 1'b0;
        repeat (100) begin
            cyc();
            if (bus.press_pulse[0]) begin
                pc++;
                if (pk < 0) pk = k;
            end
            if (bus.long_pulse[0]) lc++;
            if (k == 29) lv29 = bus.level[0];
            if (k >= 30 && bus.level[0] !== 1'b1) lvBad++;
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL clean_press_count: got %0d expected 1", pc);
        end
        checks++;
        if (pk !== 30) begin
            errors++;
            $display("FAIL clean_press_cycle: got %0d expected 30", pk);
        end
        checks++;
        if (lc !== 0) begin
            errors++;
            $display("FAIL clean_no_long: got %0d expected 0", lc);
        end
        checks++;
        if (lv29 !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_before: got %b expected 0", lv29);
        end
        checks++;
        if (lvBad !== 0) begin
            errors++;
            $display("FAIL clean_level_held: got %0d low cycles expected 0",
                     lvBad);
        end
        bus.btn_n[0] = 1'b1;
    endtask

    task automatic test_bounce();
        int pc = 0;
        int pk = -1;
        int rc = 0;
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            if (k < 60) bus.btn_n[3] = (((k / 7) % 2) == 1);
            else        bus.btn_n[3] = 1'b0;
            cyc();
            if (bus.press_pulse[3]) begin
                pc++;
                if (pk < 0) pk = k;
            end
            if (bus.release_pulse[3]) rc++;
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL bounce_press_count: got %0d expected 1", pc);
        end
        checks++;
        if (pk !== 80) begin
            errors++;
            $display("FAIL bounce_press_cycle: got %0d expected 80", pk);
        end
        checks++;
        if (rc !== 0) begin
            errors++;
            $display("FAIL bounce_no_release: got %0d expected 0", rc);
        end
        bus.btn_n[3] = 1'b1;
    endtask

    task automatic test_long_press();
        int   pk = -1;
        int   lc = 0;
        int   lk = -1;
        int   rc = 0;
        int   rk = -1;
        logic lv260 = 1'bx;
        logic lv329 = 1'bx;
        logic lv330 = 1'bx;
        apply_reset();
        for (int i = 0; i < 360; i++) begin
            if (k >= 250 && k < 265) bus.btn_n[5] = 1'b1;
            else if (k >= 300)       bus.btn_n[5] = 1'b1;
            else                     bus.btn_n[5] = 1'b0;
            cyc();
            if (bus.press_pulse[5] && pk < 0) pk = k;
            if (bus.long_pulse[5]) begin
                lc++;
                if (lk < 0) lk = k;
            end
            if (bus.release_pulse[5]) begin
                rc++;
                if (rk < 0) rk = k;
            end
            if (k == 260) lv260 = bus.level[5];
            if (k == 329) lv329 = bus.level[5];
            if (k == 330) lv330 = bus.level[5];
        end
        checks++;
        if (pk !== 30) begin
            errors++;
            $display("FAIL long_press_cycle: got %0d expected 30", pk);
        end
        checks++;
        if (lc !== 1) begin
            errors++;
            $display("FAIL long_count: got %0d expected 1", lc);
        end
        checks++;
        if (lk !== 230) begin
            errors++;
            $display("FAIL long_cycle: got %0d expected 230", lk);
        end
        checks++;
        if (rc !== 1) begin
            errors++;
            $display("FAIL long_release_count: got %0d expected 1", rc);
        end
        checks++;
        if (rk !== 330) begin
            errors++;
            $display("FAIL long_release_cycle: got %0d expected 330", rk);
        end
        checks++;
        if (lv260 !== 1'b1) begin
            errors++;
            $display("FAIL long_level_bounce: got %b expected 1", lv260);
        end
        checks++;
        if (lv329 !== 1'b1) begin
            errors++;
            $display("FAIL long_level_329: got %b expected 1", lv329);
        end
        checks++;
        if (lv330 !== 1'b0) begin
            errors++;
            $display("FAIL long_level_330: got %b expected 0", lv330);
        end
    endtask

    task automatic test_simultaneous();
        int k1 = -1;
        int k2 = -1;
        int c1 = 0;
        int other = 0;
        apply_reset();
        bus.btn_n[1] = 1'b0;
        bus.btn_n[2] = 1'b0;
        repeat (50) begin
            cyc();
            if (bus.press_pulse[1]) begin
                c1++;
                if (k1 < 0) k1 = k;
            end
            if (bus.press_pulse[2] && k2 < 0) k2 = k;
            if (((bus.press_pulse | bus.release_pulse | bus.level
                  | bus.long_pulse) & 6'b111001) != 6'd0) other++;
        end
        checks++;
        if (k1 !== 30) begin
            errors++;
            $display("FAIL simul_press1: got %0d expected 30", k1);
        end
        checks++;
        if (k2 !== 30) begin
            errors++;
            $display("FAIL simul_press2: got %0d expected 30", k2);
        end
        checks++;
        if (c1 !== 1) begin
            errors++;
            $display("FAIL simul_count1: got %0d expected 1", c1);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL simul_others: got %0d active cycles expected 0",
                     other);
        end
        bus.btn_n[1] = 1'b1;
        bus.btn_n[2] = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [24:0] outs;
        int          pc = 0;
        int          pk = -1;
        logic        lv29 = 1'bx;
        apply_reset();
        bus.btn_n[4] = 1'b0;
        repeat (40) cyc();
        checks++;
        if (bus.level[4] !== 1'b1) begin
            errors++;
            $display("FAIL mid_level_before: got %b expected 1",
                     bus.level[4]);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            outs = {bus.press_pulse, bus.release_pulse, bus.level,
                    bus.long_pulse, bus.tick_ms};
            checks++;
            if (outs !== 25'd0) begin
                errors++;
                $display("FAIL mid_reset_outs: got %h expected 0", outs);
            end
        end
        rst = 1'b0;
        k = 0;
        repeat (50) begin
            cyc();
            if (bus.press_pulse[4]) begin
                pc++;
                if (pk < 0) pk = k;
            end
            if (k == 29) lv29 = bus.level[4];
        end
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL mid_press_count: got %0d expected 1", pc);
        end
        checks++;
        if (pk !== 30) begin
            errors++;
            $display("FAIL mid_press_cycle: got %0d expected 30", pk);
        end
        checks++;
        if (lv29 !== 1'b0) begin
            errors++;
            $display("FAIL mid_level_29: got %b expected 0", lv29);
        end
        bus.btn_n[4] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_n = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
